// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer: per-bit state encoding and the
// hold-counter width helper.
package debounce_pkg;

    localparam logic [1:0] ST_LOW    = 2'd0;
    localparam logic [1:0] ST_WAIT_H = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;
    localparam logic [1:0] ST_WAIT_L = 2'd3;

    // Counter only needs to reach STABLE_TICKS-1; never narrower than one bit.
    function automatic int cnt_width(input int stable_ticks);
        int w;
        w = $clog2(stable_ticks + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced bit: two-flop synchroniser, hold-time FSM gated by tick,
// registered level plus single-cycle rise/fall pulses.
module debounce_cell
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic          s1_r, s2_r;
    logic [1:0]    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          out_r, out_s;
    logic          rise_r, rise_s;
    logic          fall_r, fall_s;

    // Next-state logic; a bounce back to the committed level abandons the count.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        out_s   = out_r;
        rise_s  = 1'b0;
        fall_s  = 1'b0;
        case (state_r)
            ST_LOW: begin
                out_s = 1'b0;
                if (s2_r) begin
                    state_s = ST_WAIT_H;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_WAIT_H: begin
                out_s = 1'b0;
                if (!s2_r) begin
                    state_s = ST_LOW;
                    cnt_s   = CNT_ZERO;
                end else if (tick && (cnt_r == CNT_LAST)) begin
                    state_s = ST_HIGH;
                    cnt_s   = CNT_ZERO;
                    out_s   = 1'b1;
                    rise_s  = 1'b1;
                end else if (tick) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_HIGH: begin
                out_s = 1'b1;
                if (!s2_r) begin
                    state_s = ST_WAIT_L;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_WAIT_L: begin
                out_s = 1'b1;
                if (s2_r) begin
                    state_s = ST_HIGH;
                    cnt_s   = CNT_ZERO;
                end else if (tick && (cnt_r == CNT_LAST)) begin
                    state_s = ST_LOW;
                    cnt_s   = CNT_ZERO;
                    out_s   = 1'b0;
                    fall_s  = 1'b1;
                end else if (tick) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_LOW;
                cnt_s   = CNT_ZERO;
                out_s   = 1'b0;
            end
        endcase
    end

    // Synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            state_r <= ST_LOW;
            cnt_r   <= CNT_ZERO;
            out_r   <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            s1_r    <= in;
            s2_r    <= s1_r;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            out_r   <= out_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    assign out  = out_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/debouncer.sv
// Multi-bit debouncer: WIDTH independent cells sharing clock, reset and the
// divider's sampling tick.
module debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int STABLE_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .in   (in[i]),
            .out  (out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Multi-bit push-button/switch debouncer directly downstream of the clock divider.
- Consumes the divider's slow `tick` as a sampling enable and synchronises raw asynchronous inputs to `clk`.
- Outputs a clean level per bit, plus single-cycle rise and fall pulses per bit.
- Feeds counters, the display and control logic that must react exactly once per press.

Parameters:
- WIDTH, 4, number of independent input bits debounced in parallel (≥1).
- STABLE_TICKS, 3, number of consecutive `tick` samples an input must hold a new value before `out` follows (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  sampling enable from the clock divider; each `clk` cycle with tick=1 counts as one sample.
- in  input  WIDTH  raw asynchronous inputs (buttons/switches).
- out  output  WIDTH  debounced level.
- rise  output  WIDTH  one-cycle pulse when `out[i]` goes 0→1.
- fall  output  WIDTH  one-cycle pulse when `out[i]` goes 1→0.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All state is cleared on negedge rst_n; no synchronous reset.
- Reset values: out=0, rise=0, fall=0, synchroniser flops=0, every bit in state LOW, every counter 0.
- Synchroniser: per bit, two-flop chain `in` → s1 → s2. `s2` is the only internal view of `in`, giving 2 `clk` cycles of latency.
- Per-bit FSM, 4 states:
  - LOW: out=0. If s2=1, go to WAIT_H with cnt=0.
  - WAIT_H: out=0.
    - If s2=0, return to LOW with cnt=0 (glitch rejected), regardless of tick.
    - Else if tick=1 and cnt==STABLE_TICKS-1, go to HIGH and set out=1. rise pulses for the cycle following that edge.
    - Else if tick=1, cnt+1.
    - Else hold.
  - HIGH: out=1. If s2=0, go to WAIT_L with cnt=0.
  - WAIT_L: mirror of WAIT_H with polarity swapped; commits to LOW, sets out=0 and pulses fall.
- Pulse timing: `rise`, `fall` and `out` are all registered. `rise[i]` is high for exactly one `clk` cycle, the same cycle `out[i]` first reads 1; likewise `fall[i]`. `rise[i]` and `fall[i]` are never both high.
- Latency: from `in` stable, `out` follows after 2 `clk` cycles (sync) plus STABLE_TICKS ticks. The first tick counted is the first tick=1 cycle after entering WAIT_x; the entry cycle itself does not count even if tick=1.
- Tick held high: each cycle with tick=1 counts, so a level-held tick degenerates to clk-rate counting. This is legal; no edge detection is done on tick.
- Width rule: cnt is $clog2(STABLE_TICKS+1) bits (minimum 1) and never exceeds STABLE_TICKS-1.
- STABLE_TICKS=1: the first tick in WAIT_x commits.
- Bits are fully independent; simultaneous commits on several bits raise several `rise`/`fall` bits in the same cycle.
- Reset mid-count: the bit returns to LOW with out=0 and no pulse. A bit held at 1 through reset release produces a normal rise after sync + STABLE_TICKS ticks.

Decomposition:
- Shared package/include `debounce_pkg` holds:
  - the state encoding localparams ST_LOW=2'd0, ST_WAIT_H=2'd1, ST_HIGH=2'd2, ST_WAIT_L=2'd3;
  - the counter-width function.
- Natural sub-module `debounce_cell`: one bit, containing the synchroniser, FSM, counter and pulse registers, with parameter STABLE_TICKS.
- `debouncer` is a generate loop of WIDTH cells sharing `clk`, `rst_n` and `tick`.

Test Plan (WIDTH=2, STABLE_TICKS=3, bench drives tick=1 one cycle in every 5):
- Reset: hold rst_n=0 with in=2'b11, release → out=2'b00 and rise=fall=0 at release. out=2'b11 with rise=2'b11 for one cycle after 2 cycles + 3 ticks.
- Clean press: in[0] 0→1 held → out[0]=1 exactly after sync + 3rd tick. rise[0] high for 1 cycle. fall never asserted. out[1] unaffected.
- Bounce: in[0] toggles 1,0,1,0 every 3 cycles for 20 cycles, then holds 1 → no rise during the bounce. A single rise occurs 3 ticks after the final stable 1.
- Release: from out[1]=1, in[1]→0 held → fall[1] one-cycle pulse after sync + 3 ticks. out[1]=0 from that cycle on.
- Tick held high: set tick=1 constantly and toggle in[0] 0→1 → out[0]=1 exactly 2+1+3 cycles after the change (sync, entry, 3 counted cycles).
- Async reset mid-count: assert rst_n=0 while bit 0 is in WAIT_H with cnt=2 → out, rise and fall go to 0 immediately with no pulse. After release, rise[0] requires a full 3 new ticks.
